// File: rtl/tqvp_pwm_capture.sv
// rtl/tqvp_pwm_capture.sv - TinyQV PWM capture peripheral: measures high time and period of one ui_in pin
// Optional deglitch filter on the sampled input: define PWMCAP_FILTER_EN.
module tqvp_pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_HIGH      = 2'd2,
    S_LOW       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             en;
  logic [2:0]       pin_sel;
  logic             freeze;
  logic             sync1, sync2;
  logic             level_q, level_cur;
  logic             rise, fall;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] high_tmp, high_tmp_nxt;
  logic [CNT_W-1:0] high_r, period_r;
  logic             valid, ovf;
  logic             publish, ovf_set;
  logic             wr_ctrl, clr, pin_chg;
  logic [15:0]      high_ext, period_ext;
  logic             unused_bits;

  assign wr_ctrl     = data_write && (address == 4'd0);
  assign clr         = wr_ctrl && data_in[7];
  assign pin_chg     = wr_ctrl && (data_in[3:1] != pin_sel);
  assign unused_bits = &{1'b0, data_in[6:5]};

  // Control register; CLR (bit 7) is an action only and is never stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      pin_sel <= 3'd0;
      freeze  <= 1'b0;
    end else if (wr_ctrl) begin
      en      <= data_in[0];
      pin_sel <= data_in[3:1];
      freeze  <= data_in[4];
    end
  end

  // Two-flop synchronizer on the selected pin, plus the last accepted level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1   <= ui_in[pin_sel];
      sync2   <= sync1;
      level_q <= level_cur;
    end
  end

`ifdef PWMCAP_FILTER_EN
  logic hist1, hist2;

  // Sample history: the level only moves once three consecutive synchronized samples agree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist1 <= 1'b0;
      hist2 <= 1'b0;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end

  assign level_cur = (sync2 == hist1 && hist1 == hist2) ? sync2 : level_q;
`else
  assign level_cur = sync2;
`endif

  assign rise = level_cur && !level_q;
  assign fall = !level_cur && level_q;

  // Measurement FSM next state; control writes and EN override the normal flow
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    high_tmp_nxt = high_tmp;
    publish      = 1'b0;
    ovf_set      = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (en) state_nxt = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        cnt_nxt = '0;
        if (rise) begin
          state_nxt = S_HIGH;
          cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_HIGH: begin
        if (cnt == CNT_MAX) begin
          ovf_set   = 1'b1;
          state_nxt = S_WAIT_RISE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (fall) begin
            high_tmp_nxt = cnt;
            state_nxt    = S_LOW;
          end
        end
      end
      default: begin
        if (cnt == CNT_MAX) begin
          ovf_set   = 1'b1;
          state_nxt = S_WAIT_RISE;
          cnt_nxt   = '0;
        end else if (rise) begin
          publish   = !freeze;
          state_nxt = S_HIGH;
          cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
    if (!en) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      publish   = 1'b0;
      ovf_set   = 1'b0;
    end
    if (clr || pin_chg) begin
      state_nxt = data_in[0] ? S_WAIT_RISE : S_IDLE;
      cnt_nxt   = '0;
      publish   = 1'b0;
      ovf_set   = 1'b0;
    end
  end

  // FSM state, running counter and captured high time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      high_tmp <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      high_tmp <= high_tmp_nxt;
    end
  end

  // Published results and flags; CLR beats a same-cycle publish or overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_r   <= '0;
      period_r <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
    end else if (clr) begin
      high_r   <= '0;
      period_r <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (publish) begin
        high_r   <= high_tmp;
        period_r <= cnt;
        valid    <= 1'b1;
      end
      if (ovf_set) ovf <= 1'b1;
    end
  end

  assign high_ext   = 16'(high_r);
  assign period_ext = 16'(period_r);
  assign uo_out     = {5'b0, level_cur, ovf, valid};

  // Combinational register read mux
  always_comb begin
    data_out = 8'h00;
    case (address)
      4'd0:    data_out = {3'b0, freeze, pin_sel, en};
      4'd1:    data_out = {3'b0, state, level_cur, ovf, valid};
      4'd2:    data_out = high_ext[7:0];
      4'd3:    data_out = high_ext[15:8];
      4'd4:    data_out = period_ext[7:0];
      4'd5:    data_out = period_ext[15:8];
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_pwm_capture.sv
// tb/tb_tqvp_pwm_capture.sv - scoreboard bench for tqvp_pwm_capture (16-bit and 8-bit counter instances)
module tb_tqvp_pwm_capture;

`ifdef PWMCAP_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [3:0] address = 4'd0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] do16, uo16, do8, uo8;

  tqvp_pwm_capture #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo16),
    .address(address), .data_write(data_write), .data_in(data_in), .data_out(do16)
  );

  tqvp_pwm_capture #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo8),
    .address(address), .data_write(data_write), .data_in(data_in), .data_out(do8)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t       sb[$];
  logic       rd_stb = 1'b0;
  int         n_total = 0;
  int         n_pass = 0;
  exp_t       cur;
  logic [7:0] act;

  // Monitor: whenever a read is presented, pop the expected value and compare
  always @(negedge clk) begin
    if (rd_stb) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_empty: read presented with no expected value");
      end else begin
        cur = sb.pop_front();
        case (cur.src)
          0:       act = do16;
          1:       act = uo16;
          2:       act = do8;
          default: act = uo8;
        endcase
        if (act === cur.exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input int src, input logic [3:0] a, input logic [7:0] v, input string n);
    exp_t e;
    e.src  = src;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
    address = a;
    rd_stb  = 1'b1;
    @(posedge clk);
    #1;
    rd_stb  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] v);
    address    = 4'd0;
    data_in    = v;
    data_write = 1'b1;
    @(posedge clk);
    #1;
    data_write = 1'b0;
  endtask

  task automatic pwm(input int pin, input int hi, input int lo, input int n, input bit noise);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < hi + lo; c++) begin
        ui_in[pin] = (c < hi);
        if (noise) ui_in[0] = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    rst = 1'b0;
    // reset state
    for (int a = 0; a < 8; a++) chk(0, 4'(a), 8'h00, $sformatf("reset_addr%0d", a));
    chk(1, 4'd0, 8'h00, "reset_uo_out");

    // basic 64/192 on pin 0
    wr(8'h01);
    pwm(0, 64, 192, 3, 0);
    chk(0, 4'd2, 8'h40, "t1_high_lo");
    chk(0, 4'd3, 8'h00, "t1_high_hi");
    chk(0, 4'd4, 8'h00, "t1_period_lo");
    chk(0, 4'd5, 8'h01, "t1_period_hi");
    chk(0, 4'd1, 8'h19, "t1_status");
    chk(1, 4'd0, 8'h01, "t1_uo_out");
    chk(0, 4'd0, 8'h01, "t1_ctrl");

    // freeze while period changes to 512
    wr(8'h11);
    pwm(0, 128, 384, 2, 0);
    wr(8'h01);
    pwm(0, 128, 384, 2, 0);
    chk(0, 4'd5, 8'h02, "unfreeze_period_hi");
    chk(0, 4'd4, 8'h00, "unfreeze_period_lo");
    chk(0, 4'd2, 8'h80, "unfreeze_high_lo");

    // frozen results must survive a changed waveform
    wr(8'h11);
    pwm(0, 64, 192, 3, 0);
    chk(0, 4'd5, 8'h02, "freeze_period_hi");
    chk(0, 4'd2, 8'h80, "freeze_high_lo");
    chk(0, 4'd0, 8'h11, "freeze_ctrl");
    wr(8'h01);

    // CLR written on the exact cycle a publish is due
    ui_in[0] = 1'b1;
    cycles(LAT - 1);
    wr(8'h81);
    chk(0, 4'd1, 8'h0C, "clr_status");
    chk(0, 4'd2, 8'h00, "clr_high_lo");
    chk(0, 4'd5, 8'h00, "clr_period_hi");
    chk(1, 4'd0, 8'h04, "clr_uo_out");

    // publish latency and a 50/100 measurement
    ui_in[0] = 1'b0;
    cycles(50);
    ui_in[0] = 1'b1;
    cycles(50);
    ui_in[0] = 1'b0;
    cycles(50);
    ui_in[0] = 1'b1;
    cycles(LAT - 1);
    chk(0, 4'd1, 8'h1C, "lat_before_publish");
    chk(0, 4'd1, 8'h15, "lat_at_publish");
    chk(0, 4'd2, 8'h32, "lat_high_lo");
    chk(0, 4'd4, 8'h64, "lat_period_lo");

    // pin 3 at 25% of 1000 with noise on pin 0
    wr(8'h07);
    pwm(3, 250, 750, 3, 1);
    ui_in[0] = 1'b0;
    chk(0, 4'd2, 8'hFA, "pin3_high_lo");
    chk(0, 4'd3, 8'h00, "pin3_high_hi");
    chk(0, 4'd4, 8'hE8, "pin3_period_lo");
    chk(0, 4'd5, 8'h03, "pin3_period_hi");
    chk(0, 4'd0, 8'h07, "pin3_ctrl");

    // overflow on the 8-bit instance with the input stuck high
    wr(8'h81);
    pwm(0, 10, 30, 2, 0);
    ui_in[0] = 1'b1;
    cycles(300);
    chk(2, 4'd1, 8'h0F, "ovf8_status");
    chk(2, 4'd2, 8'h0A, "ovf8_high_lo");
    chk(2, 4'd3, 8'h00, "ovf8_high_hi");
    chk(2, 4'd4, 8'h28, "ovf8_period_lo");
    chk(3, 4'd0, 8'h07, "ovf8_uo_out");
    chk(0, 4'd1, 8'h15, "ovf16_status");
    chk(0, 4'd4, 8'h28, "ovf16_period_lo");

    // asynchronous reset in the middle of a high phase
    rst = 1'b1;
    for (int a = 0; a < 6; a++) chk(0, 4'(a), 8'h00, $sformatf("rst_mid_addr%0d", a));
    chk(1, 4'd0, 8'h00, "rst_mid_uo_out");
    chk(2, 4'd1, 8'h00, "rst_mid_status8");
    rst = 1'b0;
    ui_in = 8'h00;

`ifdef PWMCAP_FILTER_EN
    // a 2-cycle glitch inside the low phase must not split the period
    wr(8'h01);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 100; c++) begin
        ui_in[0] = (c < 30) || (c == 60) || (c == 61);
        cycles(1);
      end
    end
    ui_in[0] = 1'b0;
    chk(0, 4'd4, 8'h64, "filt_period_lo");
    chk(0, 4'd2, 8'h1E, "filt_high_lo");
`endif

    cycles(3);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: %0d entries still queued, 0 required", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tqvp_pwm_capture.md
Name: tqvp_pwm_capture

Overview:
- Byte-register TinyQV peripheral that measures an external PWM waveform: high time and period, in clk cycles.
- It is the receive end of the team's PWM generator. It sits on the same 4-bit address / 8-bit data peripheral bus and samples one selectable ui_in pin.
- Results are published atomically once per input period.

Parameters:
- CNT_W, 16, measurement counter width (legal 8..16); result bytes above CNT_W read as 0.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- ui_in  input  8  external inputs; PWM source is pin ui_in[PIN_SEL]
- uo_out  output  8  {5'b0, LEVEL, OVF, VALID}
- address  input  4  register address
- data_write  input  1  write strobe, 1 cycle, for the register at address
- data_in  input  8  write data
- data_out  output  8  combinational read data for address

Behaviour:
- Reset: all registers 0 (EN=0, PIN_SEL=0, FREEZE=0); VALID=0, OVF=0; HIGH=0, PERIOD=0; FSM in IDLE; uo_out=0; data_out=0 for every address.
- Register map, writes:
  - addr 0 CTRL: bit0 EN, bits3:1 PIN_SEL, bit4 FREEZE, bit7 CLR.
  - CLR is a self-clearing pulse that is not stored and reads 0.
  - Writes to any other address are ignored.
- Register map, reads:
  - addr 0 CTRL.
  - addr 1 STATUS: bit0 VALID, bit1 OVF, bit2 LEVEL, bits4:3 FSM state (IDLE=0, WAIT_RISE=1, HIGH=2, LOW=3).
  - addr 2/3 HIGH[7:0]/[15:8]; addr 4/5 PERIOD[7:0]/[15:8].
  - Any other address reads 0.
- Input path: selected pin → 2-flop synchronizer → registered previous value. LEVEL is the synchronized value. Edges are detected as sync != prev.
- FSM:
  - IDLE: EN=0. Counter held at 0.
  - IDLE → WAIT_RISE when EN=1.
  - WAIT_RISE: discards any partial high phase. On a rising edge → HIGH, counter=1.
  - HIGH: counter +1 per cycle. On a falling edge → latch high_tmp = counter, then → LOW.
  - LOW: counter +1 per cycle. On a rising edge → publish, then → HIGH with counter=1.
- Publish:
  - HIGH=high_tmp, PERIOD=counter, VALID=1, all in the same cycle.
  - Skipped when FREEZE=1; the FSM still restarts.
- Count accuracy: an input high for H cycles within period P reads exactly HIGH=H, PERIOD=P. The synchronizer delays both edges equally.
- Publish latency: 3 clk after the input rising edge, fixed.
- Overflow:
  - Triggered in HIGH or LOW when the counter reaches 2^CNT_W−1.
  - Effect: OVF=1, no publish, → WAIT_RISE. Counter never wraps.
  - A constant-level input (0% or 100% duty) therefore yields OVF.
- EN cleared mid-measurement: → IDLE next cycle, partial counts discarded, results and flags retained.
- CTRL write that changes PIN_SEL while EN=1: → WAIT_RISE, counter=0.
- CLR: VALID=0, OVF=0, HIGH=0, PERIOD=0, FSM → WAIT_RISE (or IDLE if EN=0).
- CLR coinciding with a publish or overflow in the same cycle: CLR wins.
- Reset mid-operation: immediate return to reset state, asynchronously.

Optional Feature:
- Macro: PWMCAP_FILTER_EN.
- Defined: a deglitch stage follows the synchronizer. LEVEL changes only after 3 consecutive equal samples.
  - Pulses of 1–2 cycles are ignored.
  - Publish latency becomes 5 clk.
  - HIGH and PERIOD accuracy is unchanged for phases of 3 or more cycles.
- Undefined: no filter, latency 3 clk, every synchronized edge counts.

Test Plan:
- CTRL=0x01, ui_in[0] high 64 / low 192 clk, repeated → after the 2nd rising edge: HIGH=0x0040, PERIOD=0x0100, VALID=1, uo_out=0x01 or 0x05.
- CTRL=0x07 (pin 3), 25% duty with period 1000 on ui_in[3], ui_in[0] toggling randomly → HIGH=250, PERIOD=1000; the ui_in[0] activity has no effect.
- CNT_W=8, ui_in[0] held high after a rising edge for 300 clk → OVF=1, STATUS[1]=1, HIGH/PERIOD unchanged.
- VALID=1, then CTRL=0x11 (FREEZE) while the input period changes 256→512 → PERIOD stays 256. After CTRL=0x01, PERIOD=512 within 2 periods.
- Write CTRL=0x81 on the exact cycle a publish is due → VALID=0, HIGH=0, PERIOD=0, FSM=WAIT_RISE.
- Assert rst mid-HIGH → all of uo_out, STATUS, and results read 0 the same cycle. With PWMCAP_FILTER_EN, a 2-cycle glitch inside the low phase leaves PERIOD unchanged.
